// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings for the E-stage mult/div issue controller.
package md_issue_ctrl_pkg;

  // E-stage mult/div operation encodings (9-15 behave as none)
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  // Operation codes presented to the HI/LO unit
  localparam logic [2:0] XOP_MULT  = 3'b000;
  localparam logic [2:0] XOP_MULTU = 3'b001;
  localparam logic [2:0] XOP_DIV   = 3'b010;
  localparam logic [2:0] XOP_DIVU  = 3'b011;
  localparam logic [2:0] XOP_MTHI  = 3'b100;
  localparam logic [2:0] XOP_MTLO  = 3'b101;
  localparam logic [2:0] XOP_IDLE  = 3'b111;

  // Issue FSM; encodings kept identical to the legacy constants
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } md_state_t;

  // Decoded view of one E-stage mult/div operation
  typedef struct packed {
    logic       is_start_op;
    logic       is_move_to;
    logic       is_move_from;
    logic [2:0] xalu_op;
  } md_dec_t;

  // True for the unit codes that perform a division
  function automatic logic is_div_xop(input logic [2:0] op);
    return (op == XOP_DIV) || (op == XOP_DIVU);
  endfunction

endpackage

// File: rtl/md_op_decode.sv
// Combinational classifier of the E-stage mult/div operation field.
module md_op_decode
  import md_issue_ctrl_pkg::*;
(
  input  logic [3:0] i_md_op,
  output md_dec_t    o_dec
);

  // Map the E-stage op to its class and the unit op code
  always_comb begin
    o_dec              = '0;
    o_dec.xalu_op      = XOP_IDLE;
    case (i_md_op)
      MD_MULT:  begin o_dec.is_start_op  = 1'b1; o_dec.xalu_op = XOP_MULT;  end
      MD_MULTU: begin o_dec.is_start_op  = 1'b1; o_dec.xalu_op = XOP_MULTU; end
      MD_DIV:   begin o_dec.is_start_op  = 1'b1; o_dec.xalu_op = XOP_DIV;   end
      MD_DIVU:  begin o_dec.is_start_op  = 1'b1; o_dec.xalu_op = XOP_DIVU;  end
      MD_MTHI:  begin o_dec.is_move_to   = 1'b1; o_dec.xalu_op = XOP_MTHI;  end
      MD_MTLO:  begin o_dec.is_move_to   = 1'b1; o_dec.xalu_op = XOP_MTLO;  end
      MD_MFHI:  o_dec.is_move_from = 1'b1;
      MD_MFLO:  o_dec.is_move_from = 1'b1;
      default:  o_dec = o_dec;
    endcase
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue/interlock controller in front of the HI/LO mult/div unit.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 31,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [3:0]       e_md_op,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             xalu_busy,
  input  logic [31:0]      xalu_hi,
  input  logic [31:0]      xalu_lo,
  output logic [31:0]      xalu_a,
  output logic [31:0]      xalu_b,
  output logic [2:0]       xalu_op,
  output logic             xalu_start,
  output logic             stall_d,
  output logic [31:0]      md_result,
  output logic             div_zero,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_err_timeout;

  md_dec_t          w_dec;
  logic             w_md_in_e;
  logic             w_stall;
  logic             w_issue;
  logic             w_div_zero;
  logic             w_start;
  logic             w_move_to;
  logic             w_move_from;

  md_op_decode u_decode (
    .i_md_op (e_md_op),
    .o_dec   (w_dec)
  );

  // Issue/interlock decision; everything is forced quiet while reset is held
  always_comb begin
    w_md_in_e   = ~reset & e_valid &
                  (w_dec.is_start_op | w_dec.is_move_to | w_dec.is_move_from);
    w_stall     = w_md_in_e & ((r_state == ST_LAUNCH) | xalu_busy);
    w_issue     = w_md_in_e & ~w_stall;
    w_div_zero  = w_issue & w_dec.is_start_op & is_div_xop(w_dec.xalu_op) &
                  (rt_val == '0);
    w_start     = w_issue & w_dec.is_start_op & ~w_div_zero;
    w_move_to   = w_issue & w_dec.is_move_to;
    w_move_from = w_issue & w_dec.is_move_from;
  end

  // Drive the unit interface and the mfhi/mflo result
  always_comb begin
    xalu_a     = rs_val;
    xalu_b     = rt_val;
    xalu_start = w_start;
    xalu_op    = (w_start | w_move_to) ? w_dec.xalu_op : XOP_IDLE;
    stall_d    = w_stall;
    div_zero   = w_div_zero;
    md_result  = '0;
    if (w_move_from) begin
      md_result = (e_md_op == MD_MFHI) ? xalu_hi : xalu_lo;
    end
  end

  // Next-state logic: a start from WAIT only happens once BUSY has dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_start)         w_state_nxt = ST_LAUNCH;
        else if (!xalu_busy) w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Watchdog on consecutive busy cycles in WAIT; error is sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else if (!xalu_busy) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      if (r_wd_cnt != WD_MAX) r_wd_cnt <= r_wd_cnt + WD_W'(1);
      if (r_wd_cnt >= WD_LAST) r_err_timeout <= 1'b1;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl with a behavioural HI/LO unit.
module tb_md_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        xalu_busy;
  logic [31:0] xalu_hi;
  logic [31:0] xalu_lo;
  logic [31:0] xalu_a;
  logic [31:0] xalu_b;
  logic [2:0]  xalu_op;
  logic        xalu_start;
  logic        stall_d;
  logic [31:0] md_result;
  logic        div_zero;
  logic [31:0] stall_cnt;
  logic        err_timeout;

  int checks;
  int failures;
  int n_stall;

  md_issue_ctrl #(
    .TIMEOUT_CYCLES (31),
    .CNT_W          (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .e_valid     (e_valid),
    .e_md_op     (e_md_op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .xalu_busy   (xalu_busy),
    .xalu_hi     (xalu_hi),
    .xalu_lo     (xalu_lo),
    .xalu_a      (xalu_a),
    .xalu_b      (xalu_b),
    .xalu_op     (xalu_op),
    .xalu_start  (xalu_start),
    .stall_d     (stall_d),
    .md_result   (md_result),
    .div_zero    (div_zero),
    .stall_cnt   (stall_cnt),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural HI/LO unit: BUSY rises on the start edge, stays high 5 (mult)
  // or 10 (div) cycles, HI/LO update on the edge BUSY falls.
  logic        m_busy;
  logic        force_busy;
  logic [3:0]  m_rem;
  logic [31:0] m_hi, m_lo, m_nhi, m_nlo;
  logic signed [63:0] t_sa, t_sb, t_ps;
  logic [63:0] t_pu;
  assign t_sa = {{32{xalu_a[31]}}, xalu_a};
  assign t_sb = {{32{xalu_b[31]}}, xalu_b};
  assign t_ps = t_sa * t_sb;
  assign t_pu = {32'b0, xalu_a} * {32'b0, xalu_b};
  assign xalu_busy = m_busy | force_busy;
  assign xalu_hi = m_hi;
  assign xalu_lo = m_lo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_rem <= '0; m_hi <= '0; m_lo <= '0;
      m_nhi <= '0; m_nlo <= '0;
    end else begin
      if (xalu_start) begin
        m_busy <= 1'b1;
        case (xalu_op)
          3'b000: begin m_nhi <= t_ps[63:32]; m_nlo <= t_ps[31:0]; m_rem <= 4'd4; end
          3'b001: begin m_nhi <= t_pu[63:32]; m_nlo <= t_pu[31:0]; m_rem <= 4'd4; end
          3'b010: begin
            m_nlo <= (xalu_b == 0) ? '0 : 32'($signed(xalu_a) / $signed(xalu_b));
            m_nhi <= (xalu_b == 0) ? '0 : 32'($signed(xalu_a) % $signed(xalu_b));
            m_rem <= 4'd9;
          end
          default: begin
            m_nlo <= (xalu_b == 0) ? '0 : xalu_a / xalu_b;
            m_nhi <= (xalu_b == 0) ? '0 : xalu_a % xalu_b;
            m_rem <= 4'd9;
          end
        endcase
      end else if (m_busy) begin
        if (m_rem == 0) begin
          m_busy <= 1'b0; m_hi <= m_nhi; m_lo <= m_nlo;
        end else begin
          m_rem <= m_rem - 4'd1;
        end
      end
      if (!xalu_start && xalu_op == 3'b100) m_hi <= xalu_a;
      if (!xalu_start && xalu_op == 3'b101) m_lo <= xalu_a;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (stall_d && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    e_valid = v; e_md_op = op; rs_val = a; rt_val = b;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    checks = 0; failures = 0; force_busy = 1'b0;
    reset = 1'b1;
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    step(); step();
    chk("rst_op",       32'(xalu_op),     32'd7);
    chk("rst_start",    32'(xalu_start),  32'd0);
    chk("rst_stall",    32'(stall_d),     32'd0);
    chk("rst_result",   md_result,        32'd0);
    chk("rst_divzero",  32'(div_zero),    32'd0);
    chk("rst_stallcnt", stall_cnt,        32'd0);
    chk("rst_err",      32'(err_timeout), 32'd0);
    reset = 1'b0;

    // mult 3 * -4, then dependent mflo / mfhi
    drive(1'b1, 4'd1, 32'd3, 32'hFFFFFFFC);
    chk("mult_start",  32'(xalu_start), 32'd1);
    chk("mult_op",     32'(xalu_op),    32'd0);
    chk("mult_nostall",32'(stall_d),    32'd0);
    chk("mult_a",      xalu_a,          32'd3);
    step();
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    chk("mult_start_pulse", 32'(xalu_start), 32'd0);
    count_stall(n_stall);
    chk("mult_stall_len", 32'(n_stall), 32'd5);
    chk("mult_mflo",      md_result,    32'hFFFFFFF4);
    chk("mult_stallcnt",  stall_cnt,    32'd5);
    step();
    drive(1'b1, 4'd7, 32'd0, 32'd0);
    chk("mult_mfhi",     md_result,     32'hFFFFFFFF);
    chk("mfhi_nostall",  32'(stall_d),  32'd0);

    // divu 17 / 5, then mfhi / mflo
    step();
    drive(1'b1, 4'd4, 32'd17, 32'd5);
    chk("divu_start", 32'(xalu_start), 32'd1);
    chk("divu_op",    32'(xalu_op),    32'd3);
    step();
    drive(1'b1, 4'd7, 32'd0, 32'd0);
    count_stall(n_stall);
    chk("divu_stall_len", 32'(n_stall), 32'd10);
    chk("divu_mfhi",      md_result,    32'd2);
    chk("divu_stallcnt",  stall_cnt,    32'd15);
    step();
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    chk("divu_mflo",         md_result,    32'd3);
    chk("divu_mflo_nostall", 32'(stall_d), 32'd0);

    // non-md instruction and out-of-range op code behind a mult
    step();
    drive(1'b1, 4'd1, 32'd2, 32'd3);
    step();
    drive(1'b1, 4'd0, 32'd0, 32'd0);
    chk("addu_nostall", 32'(stall_d), 32'd0);
    drive(1'b1, 4'd12, 32'd0, 32'd0);
    chk("op12_nostall", 32'(stall_d), 32'd0);
    chk("op12_idle",    32'(xalu_op), 32'd7);
    drive(1'b0, 4'd8, 32'd0, 32'd0);
    chk("bubble_nostall", 32'(stall_d), 32'd0);
    repeat (8) step();
    chk("nonmd_stallcnt", stall_cnt, 32'd15);

    // div by zero: suppressed, HI/LO from the 2*3 mult stay intact
    drive(1'b1, 4'd3, 32'd9, 32'd0);
    chk("dz_pulse", 32'(div_zero),   32'd1);
    chk("dz_start", 32'(xalu_start), 32'd0);
    chk("dz_op",    32'(xalu_op),    32'd7);
    step();
    drive(1'b1, 4'd7, 32'd0, 32'd0);
    chk("dz_pulse_end", 32'(div_zero), 32'd0);
    chk("dz_nostall",   32'(stall_d),  32'd0);
    chk("dz_hi_kept",   md_result,     32'd0);
    step();
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    chk("dz_lo_kept",   md_result,     32'd6);

    // signed div -7 / 2
    step();
    drive(1'b1, 4'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_op", 32'(xalu_op), 32'd2);
    step();
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    count_stall(n_stall);
    chk("div_stall_len", 32'(n_stall), 32'd10);
    chk("div_quot",      md_result,    32'hFFFFFFFD);
    step();
    drive(1'b1, 4'd7, 32'd0, 32'd0);
    chk("div_rem",       md_result,    32'hFFFFFFFF);

    // mthi then immediate mfhi
    step();
    drive(1'b1, 4'd5, 32'hDEADBEEF, 32'd0);
    chk("mthi_op",    32'(xalu_op),    32'd4);
    chk("mthi_start", 32'(xalu_start), 32'd0);
    step();
    drive(1'b1, 4'd7, 32'd0, 32'd0);
    chk("mthi_op_end",  32'(xalu_op),  32'd7);
    chk("mthi_nostall", 32'(stall_d),  32'd0);
    chk("mthi_mfhi",    md_result,     32'hDEADBEEF);

    // asynchronous reset in the middle of a divu
    step();
    drive(1'b1, 4'd4, 32'd100, 32'd7);
    step();
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    step(); step();
    chk("mid_stall",    32'(stall_d), 32'd1);
    chk("mid_stallcnt", stall_cnt,    32'd27);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_stall",    32'(stall_d),    32'd0);
    chk("arst_op",       32'(xalu_op),    32'd7);
    chk("arst_start",    32'(xalu_start), 32'd0);
    chk("arst_stallcnt", stall_cnt,       32'd0);
    chk("arst_result",   md_result,       32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_nostall", 32'(stall_d), 32'd0);
    step();
    chk("post_rst_stallcnt", stall_cnt,   32'd0);

    // watchdog: BUSY stuck high after a mult
    drive(1'b1, 4'd1, 32'd1, 32'd1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    force_busy = 1'b1;
    repeat (31) step();
    chk("wd_below_limit", 32'(err_timeout), 32'd0);
    step();
    chk("wd_at_limit",    32'(err_timeout), 32'd1);
    force_busy = 1'b0;
    repeat (3) step();
    chk("wd_sticky",      32'(err_timeout), 32'd1);
    reset = 1'b1;
    #1;
    chk("wd_rst_clear",   32'(err_timeout), 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- E-stage issue/interlock controller sitting directly upstream of the multiply/divide unit (HI/LO unit) in the pipelined MIPS core.
- Classifies the E-stage mult/div/mthi/mtlo/mfhi/mflo operation and drives the unit's operand, op and START inputs.
- Generates the D-stage stall while the unit is committed or busy, and returns HI/LO for mfhi/mflo.
- Applies the team's divide-by-zero policy and keeps a stall-cycle counter and watchdog error.

Parameters:
- TIMEOUT_CYCLES, 31: maximum consecutive cycles BUSY may stay high before err_timeout sets.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  single pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- e_valid  in  1  E-stage holds a real (non-bubble) instruction.
- e_md_op  in  4  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=mfhi, 8=mflo; 9-15 are treated as none.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- xalu_busy  in  1  BUSY from the mult/div unit.
- xalu_hi  in  32  HIGH from the mult/div unit.
- xalu_lo  in  32  LOW from the mult/div unit.
- xalu_a  out  32  operand A to the unit (rs_val).
- xalu_b  out  32  operand B to the unit (rt_val).
- xalu_op  out  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 111 idle.
- xalu_start  out  1  one-cycle start pulse.
- stall_d  out  1  freezes F/D and inserts a bubble into E.
- md_result  out  32  HI or LO value for mfhi/mflo; 0 otherwise.
- div_zero  out  1  pulses for one cycle when a div/divu with rt_val==0 is suppressed.
- stall_cnt  out  CNT_W  count of cycles in which stall_d was asserted.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- FSM states:
  - IDLE: no operation outstanding.
  - LAUNCH: start was issued last cycle; BUSY is not yet visible from the unit.
  - WAIT: the unit is busy.
- md_in_e = e_valid and e_md_op in 1..8.
- stall_d = md_in_e and (state==LAUNCH or xalu_busy). It is combinational. Non-md instructions are never stalled.
- Issue rule: an operation issues when md_in_e is true and stall_d is 0. This is allowed from IDLE, and from WAIT once BUSY has fallen.
- mult/multu/div/divu issue:
  - xalu_start=1 for that cycle and xalu_op is set to the mapped code.
  - Next state is LAUNCH.
- div/divu with rt_val==0:
  - xalu_start=0, xalu_op=111, div_zero=1 for one cycle.
  - HI/LO are left unchanged; the state does not change.
- mthi/mtlo issue:
  - xalu_start=0 and xalu_op=100/101, for exactly that cycle.
  - The state does not change.
- mfhi/mflo issue: md_result=xalu_hi or xalu_lo (combinational); the state does not change.
- Idle output: whenever no operation issues, xalu_op=111 and xalu_start=0. This guarantees no spurious mthi/mtlo writes.
- State transitions:
  - LAUNCH always moves to WAIT on the next edge.
  - WAIT moves to IDLE on the edge where xalu_busy is sampled 0, unless a new operation issues that cycle, in which case it moves to LAUNCH.
- Timing:
  - mult/multu holds BUSY high for 5 cycles; div/divu for 10.
  - A dependent mfhi/mflo placed immediately behind the operation stalls 5 or 10 cycles respectively.
  - It then reads the fresh value, because HI/LO update on the same edge on which BUSY falls.
- Watchdog:
  - A counter counts consecutive cycles in WAIT with xalu_busy=1.
  - When it reaches TIMEOUT_CYCLES, err_timeout is set and stays set until reset.
  - The counter clears whenever busy is 0.
- stall_cnt increments on each edge where stall_d was 1 and saturates at all-ones.
- Reset (asynchronous, mid-operation included):
  - State becomes IDLE; stall_cnt=0, err_timeout=0, watchdog counter=0.
  - Outputs while reset is held: xalu_start=0, xalu_op=111, stall_d=0, div_zero=0, md_result=0.
  - The unit's own reset clears BUSY, so an aborted operation has no residual effect.

Decomposition:
- Shared package: the e_md_op encodings, the xalu_op codes (including 111 idle), and the FSM state encoding (IDLE=0, LAUNCH=1, WAIT=2).
- One natural sub-module, md_op_decode: a combinational mapping from e_md_op to {is_start_op, is_move_to, is_move_from, xalu_op}.

Test Plan:
- Mult then mflo: mult rs=3, rt=-4, then mflo.
  - Response: start for 1 cycle, then stall_d for exactly 5 cycles.
  - md_result=32'hFFFFFFF4 and HI=32'hFFFFFFFF; stall_cnt=5.
- Divu then mfhi: divu rs=17, rt=5, then mfhi.
  - Response: stall_d for 10 cycles; md_result=2; a following mflo returns 3 with no stall.
- Divide by zero: div rt=0.
  - Response: div_zero pulses once, xalu_start stays 0, and no stall on a following mfhi.
  - HI/LO keep their prior values (e.g. 0 after reset).
- mthi then mfhi: mthi rs=32'hDEADBEEF followed immediately by mfhi.
  - Response: xalu_op=100 for 1 cycle; mfhi returns 32'hDEADBEEF with no stall.
- Non-md instruction behind mult: an addu directly behind a mult.
  - Response: stall_d stays 0 for it.
- Reset mid-operation: reset asserted asynchronously mid-div.
  - Response: state IDLE immediately; xalu_op=111 and stall_cnt=0.
  - A subsequent mflo does not stall.
